// File: rtl/intr_ctrl.sv
// Prioritised edge-triggered interrupt controller with a single-bit irq to the core and a 12-bit ISR vector.
// Define INTC_NEST_EN to enable nested (preemptive) servicing with one in-service bit per source.
module intr_ctrl #(
  parameter int          N_SRC     = 8,
  parameter logic [11:0] VEC_BASE  = 12'hFF0,
  parameter int          VEC_SHIFT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_data,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [11:0]      vector,
  output logic [2:0]       active_id,
  output logic [N_SRC-1:0] pending,
  output logic             in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;
  logic [11:0]      vector_q, vector_d;
  logic [2:0]       active_id_q, active_id_d;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] req_vec;
`ifdef INTC_NEST_EN
  logic [N_SRC-1:0] isr_bits_q, isr_bits_d;
  logic [N_SRC-1:0] isr_rem;
  logic [N_SRC-1:0] preempt;
`else
  logic             in_service_q, in_service_d;
`endif

  // Lowest set index wins; an all-zero input returns 0 and is never used as a winner.
  function automatic logic [2:0] lowest(input logic [N_SRC-1:0] v);
    lowest = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  function automatic logic [N_SRC-1:0] onehot(input logic [2:0] id);
    onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (3'(i) == id) onehot[i] = 1'b1;
    end
  endfunction

  function automatic logic [11:0] vec_of(input logic [2:0] id);
    vec_of = VEC_BASE + (12'(id) << VEC_SHIFT);
  endfunction

  always_comb begin
    state_d     = state_q;
    src_d       = irq_src;
    mask_d      = mask_wr ? mask_data : mask_q;
    irq_d       = irq_q;
    vector_d    = vector_q;
    active_id_d = active_id_q;
    clr         = '0;
    req_vec     = pending_q & mask_q;
`ifdef INTC_NEST_EN
    isr_bits_d  = isr_bits_q;
    isr_rem     = isr_bits_q & ~onehot(lowest(isr_bits_q));
    // Only sources strictly below the highest-priority in-service source may preempt.
    preempt     = req_vec & (onehot(lowest(isr_bits_q)) - 1'b1);
`else
    in_service_d = in_service_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          active_id_d = lowest(req_vec);
          vector_d    = vec_of(lowest(req_vec));
          irq_d       = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          clr     = onehot(active_id_q);
          irq_d   = 1'b0;
          state_d = SERVICE;
`ifdef INTC_NEST_EN
          isr_bits_d = isr_bits_q | onehot(active_id_q);
`else
          in_service_d = 1'b1;
`endif
        end else if (!(|(mask_q & onehot(active_id_q)))) begin
          irq_d   = 1'b0;
          state_d = IDLE;
`ifdef INTC_NEST_EN
          if (|isr_bits_q) begin
            state_d     = SERVICE;
            active_id_d = lowest(isr_bits_q);
            vector_d    = vec_of(lowest(isr_bits_q));
          end
`endif
        end
      end
      SERVICE: begin
`ifdef INTC_NEST_EN
        if (eoi) begin
          isr_bits_d = isr_rem;
          if (|isr_rem) begin
            active_id_d = lowest(isr_rem);
            vector_d    = vec_of(lowest(isr_rem));
          end else begin
            state_d = IDLE;
          end
        end else if (|preempt) begin
          active_id_d = lowest(preempt);
          vector_d    = vec_of(lowest(preempt));
          irq_d       = 1'b1;
          state_d     = REQ;
        end
`else
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // A new edge on the bit being acknowledged keeps it pending.
    pending_d = (pending_q & ~clr) | (irq_src & ~src_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      irq_q       <= 1'b0;
      vector_q    <= '0;
      active_id_q <= '0;
`ifdef INTC_NEST_EN
      isr_bits_q  <= '0;
`else
      in_service_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      irq_q       <= irq_d;
      vector_q    <= vector_d;
      active_id_q <= active_id_d;
`ifdef INTC_NEST_EN
      isr_bits_q  <= isr_bits_d;
`else
      in_service_q <= in_service_d;
`endif
    end
  end

  assign irq       = irq_q;
  assign vector    = vector_q;
  assign active_id = active_id_q;
  assign pending   = pending_q;
`ifdef INTC_NEST_EN
  assign in_service = |isr_bits_q;
`else
  assign in_service = in_service_q;
`endif

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a default instance plus a VEC_BASE=12'hFFE instance for vector wrap.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_src;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       ack;
  logic       eoi;

  logic       irq, w_irq;
  logic [11:0] vector, w_vector;
  logic [2:0] active_id, w_active_id;
  logic [7:0] pending, w_pending;
  logic       in_service, w_in_service;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  intr_ctrl u_dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .mask_wr(mask_wr),
    .mask_data(mask_data), .ack(ack), .eoi(eoi), .irq(irq), .vector(vector),
    .active_id(active_id), .pending(pending), .in_service(in_service)
  );

  intr_ctrl #(.VEC_BASE(12'hFFE)) u_wrap (
    .clk(clk), .reset(reset), .irq_src(irq_src), .mask_wr(mask_wr),
    .mask_data(mask_data), .ack(ack), .eoi(eoi), .irq(w_irq), .vector(w_vector),
    .active_id(w_active_id), .pending(w_pending), .in_service(w_in_service)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; mask_wr = 1'b0; mask_data = '0; ack = 1'b0; eoi = 1'b0;
    step(); step();
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_vector", 32'(vector), 32'h0);
    chk("rst_active", 32'(active_id), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_insvc", 32'(in_service), 32'h0);

    // Single source 3
    reset = 1'b0; mask_wr = 1'b1; mask_data = 8'hFF; step();
    mask_wr = 1'b0; irq_src = 8'h08; step();
    chk("t1_pending", 32'(pending), 32'h08);
    chk("t1_irq_early", 32'(irq), 32'h0);
    irq_src = 8'h00; step();
    chk("t1_irq", 32'(irq), 32'h1);
    chk("t1_active", 32'(active_id), 32'h3);
    chk("t1_vector", 32'(vector), 32'hFF6);
    chk("t1_wrap_vec", 32'(w_vector), 32'h004);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t1_insvc", 32'(in_service), 32'h1);
    chk("t1_irq_ack", 32'(irq), 32'h0);
    chk("t1_pend_ack", 32'(pending), 32'h00);
    eoi = 1'b1; step(); eoi = 1'b0;
    chk("t1_insvc_eoi", 32'(in_service), 32'h0);

    // Simultaneous sources 5 and 2
    irq_src = 8'h24; step();
    irq_src = 8'h00; step();
    chk("t2_irq", 32'(irq), 32'h1);
    chk("t2_active", 32'(active_id), 32'h2);
    chk("t2_vector", 32'(vector), 32'hFF4);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t2_pending", 32'(pending), 32'h20);
    eoi = 1'b1; step(); eoi = 1'b0;
    chk("t2_idle_gap", 32'(irq), 32'h0);
    step();
    chk("t2_irq5", 32'(irq), 32'h1);
    chk("t2_active5", 32'(active_id), 32'h5);
    chk("t2_vector5", 32'(vector), 32'hFFA);
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;

    // Masked event waits until unmasked
    mask_wr = 1'b1; mask_data = 8'h00; step();
    mask_wr = 1'b0; irq_src = 8'h01; step();
    irq_src = 8'h00;
    chk("t3_pending", 32'(pending), 32'h01);
    step();
    chk("t3_irq_masked", 32'(irq), 32'h0);
    mask_wr = 1'b1; mask_data = 8'h01; step(); mask_wr = 1'b0;
    chk("t3_irq_wr1", 32'(irq), 32'h0);
    step();
    chk("t3_irq_wr2", 32'(irq), 32'h1);
    chk("t3_active", 32'(active_id), 32'h0);
    chk("t3_wrap_vec0", 32'(w_vector), 32'hFFE);
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;

    // Mask-clear withdraws a request in REQ
    mask_wr = 1'b1; mask_data = 8'hFF; step(); mask_wr = 1'b0;
    irq_src = 8'h10; step();
    irq_src = 8'h00; step();
    chk("t4_irq", 32'(irq), 32'h1);
    chk("t4_active", 32'(active_id), 32'h4);
    mask_wr = 1'b1; mask_data = 8'hEF; step(); mask_wr = 1'b0;
    chk("t4_irq_hold", 32'(irq), 32'h1);
    step();
    chk("t4_irq_drop", 32'(irq), 32'h0);
    chk("t4_pending", 32'(pending), 32'h10);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t4_ack_ign_p", 32'(pending), 32'h10);
    chk("t4_ack_ign_s", 32'(in_service), 32'h0);
    chk("t4_ack_ign_i", 32'(irq), 32'h0);

    // Vector wrap on source 1, then eoi in IDLE
    mask_wr = 1'b1; mask_data = 8'h02; step(); mask_wr = 1'b0;
    irq_src = 8'h02; step();
    irq_src = 8'h00; step();
    chk("t5_active", 32'(active_id), 32'h1);
    chk("t5_vector", 32'(vector), 32'hFF2);
    chk("t5_wrap_vec", 32'(w_vector), 32'h000);
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    chk("t5_eoi_idle_i", 32'(irq), 32'h0);
    chk("t5_eoi_idle_s", 32'(in_service), 32'h0);
    chk("t5_eoi_idle_p", 32'(pending), 32'h10);
    chk("t5_eoi_idle_a", 32'(active_id), 32'h1);

    // Reset while in SERVICE
    mask_wr = 1'b1; mask_data = 8'hFF; step(); mask_wr = 1'b0;
    step();
    chk("t6_active", 32'(active_id), 32'h4);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t6_insvc", 32'(in_service), 32'h1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_rst_irq", 32'(irq), 32'h0);
    chk("t6_rst_insvc", 32'(in_service), 32'h0);
    chk("t6_rst_pend", 32'(pending), 32'h00);
    chk("t6_rst_vec", 32'(vector), 32'h000);
    irq_src = 8'h01; step();
    irq_src = 8'h00; step();
    chk("t6_mask_zero", 32'(irq), 32'h0);

    // New edge on the bit being acknowledged stays pending
    mask_wr = 1'b1; mask_data = 8'hFF; step(); mask_wr = 1'b0;
    step();
    chk("t7_irq", 32'(irq), 32'h1);
    irq_src = 8'h01; ack = 1'b1; step(); ack = 1'b0; irq_src = 8'h00;
    chk("t7_pend_kept", 32'(pending), 32'h01);
    chk("t7_insvc", 32'(in_service), 32'h1);
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    chk("t7_rearb", 32'(irq), 32'h1);
    chk("t7_rearb_id", 32'(active_id), 32'h0);

`ifdef INTC_NEST_EN
    // Nested preemption of source 6 by source 1
    reset = 1'b1; step(); reset = 1'b0;
    mask_wr = 1'b1; mask_data = 8'hFF; step(); mask_wr = 1'b0;
    irq_src = 8'h40; step();
    irq_src = 8'h00; step();
    ack = 1'b1; step(); ack = 1'b0;
    irq_src = 8'h02; step();
    irq_src = 8'h00; step();
    chk("n_irq", 32'(irq), 32'h1);
    chk("n_active1", 32'(active_id), 32'h1);
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    chk("n_active6", 32'(active_id), 32'h6);
    chk("n_insvc", 32'(in_service), 32'h1);
    eoi = 1'b1; step(); eoi = 1'b0;
    chk("n_insvc_done", 32'(in_service), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
